// File: rtl/arm_dp_issue_pkg.sv
// arm_dp_issue_pkg: shared ALU select codes, DP opcodes, cond codes, shift types, FSM states and helpers.
package arm_dp_issue_pkg;
  localparam logic [3:0] ALU_AND = 4'h0, ALU_EOR = 4'h1, ALU_SUB = 4'h2, ALU_RSB = 4'h3,
                         ALU_ADD = 4'h4, ALU_ORR = 4'hC, ALU_BIC = 4'hE;
  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
                         OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
                         OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
                         OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;
  localparam logic [3:0] COND_AL = 4'hE, COND_NV = 4'hF;
  localparam logic [1:0] SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3;
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] s);
    return (x >> s) | (x << (6'd32 - {1'b0, s}));
  endfunction
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/arm_dp_issue_shifter.sv
// arm_dp_issue_shifter: combinational operand-2 generator (rotated imm8 or imm-shifted Rm) with legality flag.
module arm_dp_issue_shifter
  import arm_dp_issue_pkg::*;
(
  input  logic        imm,
  input  logic [11:0] field,
  input  logic [31:0] rm,
  output logic [31:0] op2,
  output logic        legal
);
  logic [4:0] amt;
  logic [1:0] typ;
  logic [31:0] asr, sh;
  assign amt = field[11:7];
  assign typ = field[6:5];
  assign asr = $signed(rm) >>> amt;
  // A zero shift amount on LSR/ASR encodes a shift by 32
  assign sh = typ == SH_LSL ? rm << amt :
              typ == SH_LSR ? (amt == 5'd0 ? 32'h0 : rm >> amt) :
              typ == SH_ASR ? (amt == 5'd0 ? {32{rm[31]}} : asr) :
              ror32(rm, amt);
  assign op2 = imm ? ror32({24'h0, field[7:0]}, {field[11:8], 1'b0}) : sh;
  assign legal = imm || (!field[4] && !(typ == SH_ROR && amt == 5'd0));
endmodule

// File: rtl/arm_dp_issue.sv
// arm_dp_issue: ARM data-processing operand-issue stage driving arm_alu and the regfile write port.
// Optional condition evaluation against nzcv enabled by ARM_DP_COND_EN.
module arm_dp_issue
  import arm_dp_issue_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [3:0]  rn_addr,
  output logic [3:0]  rm_addr,
  input  logic [31:0] rn_data,
  input  logic [31:0] rm_data,
  input  logic [3:0]  nzcv,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_op_sel,
  input  logic [31:0] alu_out,
  output logic        rd_we,
  output logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        illegal
);
  state_t state, state_n;
  logic [3:0] opc, sel;
  logic [31:0] op2, op1;
  logic imm, sh_legal, uses_rn, writes, legal, cond_ok, cond_legal, legal_q, wr_q;
  assign rn_addr = instr[19:16];
  assign rm_addr = instr[3:0];
  assign opc = instr[24:21];
  assign imm = instr[25];
`ifdef ARM_DP_COND_EN
  logic unused;
  assign unused = instr[20];
  assign cond_ok = cond_pass(instr[31:28], nzcv);
  assign cond_legal = instr[31:28] != COND_NV;
`else
  logic unused;
  assign unused = ^{instr[31:28], instr[20], nzcv};
  assign cond_ok = 1'b1;
  assign cond_legal = 1'b1;
`endif
  arm_dp_issue_shifter u_shifter (
    .imm   (imm),
    .field (instr[11:0]),
    .rm    (rm_data),
    .op2   (op2),
    .legal (sh_legal)
  );
  always_comb begin
    uses_rn = opc != OP_MOV && opc != OP_MVN;
    writes = opc[3:2] != 2'b10;
    sel = opc == OP_MOV ? ALU_ORR :
          opc == OP_MVN ? ALU_BIC :
          opc == OP_TST ? ALU_AND :
          opc == OP_TEQ ? ALU_EOR :
          opc == OP_CMP ? ALU_SUB :
          opc == OP_CMN ? ALU_ADD : opc;
    op1 = opc == OP_MOV ? 32'h0 : opc == OP_MVN ? 32'hFFFF_FFFF : rn_data;
    legal = instr[27:26] == 2'b00 && !(opc == OP_ADC || opc == OP_SBC || opc == OP_RSC) &&
            sh_legal && !(uses_rn && rn_addr == 4'd15) && !(!imm && rm_addr == 4'd15) &&
            instr[15:12] != 4'd15 && cond_legal;
    state_n = state == IDLE ? (instr_valid ? EXEC : IDLE) : state == EXEC ? WB : IDLE;
  end
  assign instr_ready = state == IDLE;
  assign done = state == WB;
  assign rd_we = done && legal_q && wr_q;
  assign illegal = done && !legal_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      alu_op1 <= 32'h0;
      alu_op2 <= 32'h0;
      alu_op_sel <= ALU_AND;
      rd_addr <= 4'h0;
      rd_data <= 32'h0;
      legal_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && instr_valid) begin
        alu_op1 <= op1;
        alu_op2 <= op2;
        alu_op_sel <= sel;
        rd_addr <= instr[15:12];
        legal_q <= legal;
        wr_q <= writes && cond_ok;
      end
      if (state == EXEC) rd_data <= alu_out;
    end
  end
endmodule

// File: tb/tb_arm_dp_issue.sv
// tb_arm_dp_issue: directed-vector scoreboard bench for arm_dp_issue with a behavioural arm_alu and regfile.
module tb_arm_dp_issue;
  import arm_dp_issue_pkg::*;
  typedef struct {
    string       tag;
    logic        ops;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  sel;
    logic        we;
    logic        ill;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;
  logic clk = 0, reset = 1, instr_valid = 0;
  logic [31:0] instr = 0, rn_data, rm_data, alu_op1, alu_op2, alu_out, rd_data;
  logic [3:0] nzcv = 0, rn_addr, rm_addr, alu_op_sel, rd_addr;
  logic instr_ready, rd_we, done, illegal;
  logic [31:0] rf [16];
  exp_t sb[$];
  int acc_q[$];
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0;
  always #5 clk = ~clk;
  arm_dp_issue dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rn_addr(rn_addr), .rm_addr(rm_addr), .rn_data(rn_data), .rm_data(rm_data), .nzcv(nzcv),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op_sel(alu_op_sel), .alu_out(alu_out),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data), .done(done), .illegal(illegal)
  );
  assign rn_data = rf[rn_addr];
  assign rm_data = rf[rm_addr];
  always_comb begin
    case (alu_op_sel)
      ALU_AND: alu_out = alu_op1 & alu_op2;
      ALU_EOR: alu_out = alu_op1 ^ alu_op2;
      ALU_SUB: alu_out = alu_op1 - alu_op2;
      ALU_RSB: alu_out = alu_op2 - alu_op1;
      ALU_ADD: alu_out = alu_op1 + alu_op2;
      ALU_ORR: alu_out = alu_op1 | alu_op2;
      ALU_BIC: alu_out = alu_op1 & ~alu_op2;
      default: alu_out = 32'h0;
    endcase
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask
  function automatic exp_t mk(input string tag, input logic ops, input logic [31:0] op1, op2,
                              input logic [3:0] sel, input logic we, ill, input logic [3:0] addr,
                              input logic [31:0] data);
    exp_t e;
    e.tag = tag; e.ops = ops; e.op1 = op1; e.op2 = op2; e.sel = sel;
    e.we = we; e.ill = ill; e.addr = addr; e.data = data;
    return e;
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && instr_valid && instr_ready) acc_q.push_back(cyc);
  end
  // Monitor: every retire pulse is matched against the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_we"}, rd_we, e.we);
        chk({e.tag, "_ill"}, illegal, e.ill);
        if (e.we) begin
          chk({e.tag, "_addr"}, rd_addr, e.addr);
          chk({e.tag, "_data"}, rd_data, e.data);
        end
        if (e.ops) begin
          chk({e.tag, "_op1"}, alu_op1, e.op1);
          chk({e.tag, "_op2"}, alu_op2, e.op2);
          chk({e.tag, "_sel"}, alu_op_sel, e.sel);
        end
      end
    end
  end
  task automatic send(input logic [31:0] i, input exp_t e);
    int n = 0;
    while (!instr_ready && n < 10) begin @(negedge clk); n++; end
    if (!instr_ready) chk("ready_timeout", instr_ready, 1);
    instr = i;
    instr_valid = 1;
    sb.push_back(e);
    @(posedge clk);
    #1 instr_valid = 0;
  endtask
  initial begin
    int n, d0, a0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'd32;
    rf[1] = 32'd96;
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_op1", alu_op1, 0);
    chk("rst_op2", alu_op2, 0);
    chk("rst_sel", alu_op_sel, ALU_AND);
    chk("rst_flags", {rd_we, done, illegal}, 0);
    chk("rst_rd", {rd_addr, rd_data}, 0);
    reset = 0;
    @(negedge clk);
    send(32'hE0802001, mk("add", 1, 32'h20, 32'h60, ALU_ADD, 1, 0, 2, 32'h80));
    send(32'hE3A034FF, mk("mov", 1, 32'h0, 32'hFF000000, ALU_ORR, 1, 0, 3, 32'hFF000000));
    send(32'hE0A21003, mk("adc", 0, 0, 0, 0, 0, 1, 0, 0));
`ifdef ARM_DP_COND_EN
    send(32'h00802001, mk("addeq", 1, 32'h20, 32'h60, ALU_ADD, 0, 0, 2, 32'h0));
`else
    send(32'h00802001, mk("addeq", 1, 32'h20, 32'h60, ALU_ADD, 1, 0, 2, 32'h80));
`endif
    send(32'hE0802021, mk("lsr0", 1, 32'h20, 32'h0, ALU_ADD, 1, 0, 2, 32'h20));
    send(32'hE0415200, mk("sub_lsl4", 1, 32'h60, 32'h200, ALU_SUB, 1, 0, 5, 32'hFFFFFE60));
    send(32'hE2806F3F, mk("add_rot", 1, 32'h20, 32'hFC, ALU_ADD, 1, 0, 6, 32'h11C));
    send(32'hE3E04001, mk("mvn", 1, 32'hFFFFFFFF, 32'h1, ALU_BIC, 1, 0, 4, 32'hFFFFFFFE));
    send(32'hE1500001, mk("cmp", 1, 32'h20, 32'h60, ALU_SUB, 0, 0, 0, 0));
    send(32'hE08F2001, mk("rn_pc", 0, 0, 0, 0, 0, 1, 0, 0));
    send(32'hE0802311, mk("regshift", 0, 0, 0, 0, 0, 1, 0, 0));
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    rf[1] = 32'h8000_0000;
    send(32'hE0802041, mk("asr0", 1, 32'h20, 32'hFFFFFFFF, ALU_ADD, 1, 0, 2, 32'h1F));
    send(32'hE0802061, mk("rrx", 0, 0, 0, 0, 0, 1, 0, 0));
    n = 0;
    while (!instr_ready && n < 10) begin @(negedge clk); n++; end
    a0 = acc_q.size();
    instr = 32'hE0802001;
    instr_valid = 1;
    sb.push_back(mk("b2b_add", 1, 32'h20, 32'h80000000, ALU_ADD, 1, 0, 2, 32'h80000020));
    @(posedge clk);
    #1 instr = 32'hE3A034FF;
    sb.push_back(mk("b2b_mov", 1, 32'h0, 32'hFF000000, ALU_ORR, 1, 0, 3, 32'hFF000000));
    n = 0;
    while (acc_q.size() < a0 + 2 && n < 10) begin @(negedge clk); n++; end
    instr_valid = 0;
    chk("b2b_accepts", acc_q.size(), a0 + 2);
    if (acc_q.size() >= a0 + 2) chk("b2b_spacing", acc_q[a0 + 1] - acc_q[a0], 3);
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    while (!instr_ready && n < 30) begin @(negedge clk); n++; end
    d0 = done_cnt;
    instr = 32'hE0802001;
    instr_valid = 1;
    @(posedge clk);
    #1 instr_valid = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("abort_ready_in_rst", instr_ready, 1);
    reset = 0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_we", rd_we, 0);
    end
    chk("abort_no_done", done_cnt, d0);
    chk("abort_ready", instr_ready, 1);
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
